alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Registered execute stage that consumes the 4-bit ALU selection code produced by the ALU control unit, together with two 32-bit operands, and returns a 32-bit result plus zero flag. Single-cycle ops (logic, add/sub, shifts, compare) complete with one cycle of latency. MUL runs on an iterative shift-add datapath over 32 cycles. Input and output use valid/ready handshakes so the stage can stall the pipeline during multiplies.

## Interface
- XLEN, 32, operand/result width; MUL iteration count equals XLEN
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operation presented
- in_ready  out  1  stage can accept this cycle
- alu_sel  in  4  ALU selection code
- op_a  in  XLEN  operand A (rs1)
- op_b  in  XLEN  operand B (rs2/imm)
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- illegal  out  1  alu_sel not in opcode set

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 XOR, 0111 SLT (signed), 1000 SLL, 1001 SRL, 1010 SRA, 1100 MUL (low XLEN bits). All other codes are illegal.
- Shift amount = op_b[4:0]; upper bits ignored. ADD/SUB/MUL wrap modulo 2^XLEN. SLT result is 0 or 1, zero-extended.
- Illegal code: completes as single-cycle op, result = 0, zero = 1, illegal = 1.
- States: IDLE, MUL, HOLD.
  - IDLE: accept when in_valid && in_ready. Single-cycle op -> compute, load output regs, go HOLD. MUL -> latch multiplicand/multiplier, clear accumulator and counter, go MUL.
  - MUL: one iteration per cycle. If multiplier LSB = 1, add multiplicand to accumulator. Shift multiplicand left and multiplier right. After iteration XLEN-1, load result, go HOLD.
  - HOLD: out_valid = 1. On out_ready, either go IDLE or take a new accepted op (back-to-back).
- in_ready = (state == IDLE) || (state == HOLD && out_ready).
- Output regs (result, zero, illegal) are stable while out_valid && !out_ready.
- Reset mid-MUL: operation discarded, state -> IDLE, no out_valid pulse.

## Timing
- Reset values: in_ready 1 (state IDLE), out_valid 0, result 0, zero 0, illegal 0. The counter and internal registers are also 0.
- Single-cycle op accepted at edge N: out_valid high after edge N, result valid from that cycle.
- MUL accepted at edge N: out_valid rises after edge N+XLEN (32 cycles in MUL state). in_ready is low throughout.
- Throughput: one single-cycle op per clock when out_ready held high. Accept and drain in the same cycle are legal.
- in_valid with in_ready low: the input is ignored and must be held by the producer.
- No combinational path from op_a/op_b/alu_sel to any output. The only combinational path to in_ready is from out_ready.

## Structure
- Package alu_pkg: localparam opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL), state encoding (S_IDLE, S_MUL, S_HOLD), and an is_legal_sel function. The ALU control unit shares these constants.
- Sub-module mul_iter holds the shift-add datapath: start, operands, busy, done, product, and a 5-bit counter. The top module holds the FSM, the single-cycle datapath, and the output registers.

## Test plan
- Reset mid-MUL: assert rst at cycle 10 of a MUL -> out_valid stays 0, in_ready = 1 next cycle, result = 0.
- ADD 0xFFFFFFFF + 1 -> result 0x00000000, zero = 1, out_valid one cycle after accept. SUB 5 - 7 -> 0xFFFFFFFE, zero = 0.
- SRA 0x80000000 by op_b = 0x24 (shamt 4) -> 0xF8000000. SRL same -> 0x08000000. SLT -1 < 1 -> 1.
- MUL 0x0001_0003 × 0x0000_0005 -> 0x0005_000F after exactly 32 busy cycles. in_ready low throughout; a second op driven during the MUL is not accepted.
- Back-to-back: 4 ADDs with out_ready = 1 -> 4 results on 4 consecutive cycles. Holding out_ready = 0 for 3 cycles keeps result stable and in_ready = 0.
- alu_sel = 1111, op_a = 0x1234 -> illegal = 1, result = 0, zero = 1. The next legal op clears illegal.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute stage and the ALU control unit.
//   XLEN / CNT_W  : datapath width and multiply iteration counter width
//   ALU_*         : 4-bit ALU selection codes
//   state_e       : execute-stage FSM encoding (S_IDLE, S_MUL, S_HOLD)
//   is_legal_sel  : 1 when a selection code belongs to the supported opcode set
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_MUL = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_HOLD = 2'b10
    } state_e;

    function automatic logic is_legal_sel(input logic [3:0] sel);
        logic legal_v;
        case (sel)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR,
            ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL: legal_v = 1'b1;
            default:                                     legal_v = 1'b0;
        endcase
        return legal_v;
    endfunction

endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// mul_iter: iterative shift-add multiplier producing the low XLEN bits of mcand*mplier.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : latch operands and begin XLEN iterations
//   mcand, mplier   : operands sampled on start
//   busy            : iterations in progress
//   done            : final iteration happens on this cycle's edge; product is valid now
//   product         : accumulator value after the final iteration (valid with done)
module mul_iter
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] mcand,
    input  logic [XLEN-1:0] mplier,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    logic [XLEN-1:0]  mcand_r;
    logic [XLEN-1:0]  mplier_r;
    logic [XLEN-1:0]  acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [XLEN-1:0]  addend_s;
    logic [XLEN-1:0]  acc_next_s;

    // Partial product for the current iteration and the resulting accumulator value.
    always_comb begin
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {XLEN{1'b0}};
        end
        acc_next_s = acc_r + addend_s;
    end

    // The last iteration's sum is handed out directly so the caller can register it
    // on the same edge, giving exactly XLEN cycles from start to result.
    assign busy    = busy_r;
    assign done    = busy_r && (cnt_r == LAST_CNT);
    assign product = acc_next_s;

    // Operand latch and one shift-add iteration per cycle while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r  <= {XLEN{1'b0}};
            mplier_r <= {XLEN{1'b0}};
            acc_r    <= {XLEN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= mcand;
            mplier_r <= mplier;
            acc_r    <= {XLEN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
            cnt_r    <= cnt_r + 5'd1;
            busy_r   <= (cnt_r != LAST_CNT);
        end else begin
            busy_r   <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute stage with valid/ready handshakes.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operation handshake (in_ready depends combinationally on out_ready only)
//   alu_sel, op_a, op_b  : selection code and operands
//   out_valid / out_ready: result handshake
//   result, zero, illegal: registered result, result==0 flag, unsupported-code flag
// Single-cycle ops finish one cycle after acceptance; MUL takes XLEN cycles in mul_iter.
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    state_e          state_r;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;
    logic            zero_r;
    logic            illegal_r;

    logic            accept_s;
    logic            mul_start_s;
    logic            legal_s;
    logic [4:0]      shamt_s;
    logic            slt_s;
    logic [XLEN-1:0] alu_res_s;
    logic            mul_busy_s;
    logic            mul_done_s;
    logic [XLEN-1:0] mul_prod_s;

    // A held result may be replaced in the same cycle it is consumed.
    assign in_ready    = (state_r == S_IDLE) || ((state_r == S_HOLD) && out_ready);
    assign accept_s    = in_valid && in_ready;
    assign mul_start_s = accept_s && (alu_sel == ALU_MUL);
    assign legal_s     = is_legal_sel(alu_sel);
    assign shamt_s     = op_b[4:0];
    assign slt_s       = ($signed(op_a) < $signed(op_b));

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign illegal   = illegal_r;

    // Single-cycle datapath; MUL and illegal codes yield 0 here.
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (alu_sel)
            ALU_AND: alu_res_s = op_a & op_b;
            ALU_OR:  alu_res_s = op_a | op_b;
            ALU_ADD: alu_res_s = op_a + op_b;
            ALU_SUB: alu_res_s = op_a - op_b;
            ALU_XOR: alu_res_s = op_a ^ op_b;
            ALU_SLT: alu_res_s = {{(XLEN-1){1'b0}}, slt_s};
            ALU_SLL: alu_res_s = op_a << shamt_s;
            ALU_SRL: alu_res_s = op_a >> shamt_s;
            ALU_SRA: alu_res_s = $unsigned($signed(op_a) >>> shamt_s);
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    mul_iter u_mul_iter (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .mcand   (op_a),
        .mplier  (op_b),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Stage FSM and output registers; outputs only change on accept, MUL completion or drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_HOLD: begin
                    if (accept_s) begin
                        if (alu_sel == ALU_MUL) begin
                            state_r     <= S_MUL;
                            out_valid_r <= 1'b0;
                        end else begin
                            state_r     <= S_HOLD;
                            out_valid_r <= 1'b1;
                            result_r    <= alu_res_s;
                            zero_r      <= (alu_res_s == {XLEN{1'b0}});
                            illegal_r   <= !legal_s;
                        end
                    end else if ((state_r == S_HOLD) && out_ready) begin
                        state_r     <= S_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= state_r;
                    end
                end
                S_MUL: begin
                    if (mul_done_s) begin
                        state_r     <= S_HOLD;
                        out_valid_r <= 1'b1;
                        result_r    <= mul_prod_s;
                        zero_r      <= (mul_prod_s == {XLEN{1'b0}});
                        illegal_r   <= 1'b0;
                    end else if (!mul_busy_s) begin
                        // Multiplier lost its operation without finishing: recover to idle.
                        state_r     <= S_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= S_MUL;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit. The driver pushes the
// expected response of every accepted op; an independent monitor pops and compares
// on each output transfer and checks output stability while stalled.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    alu_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_sel   (alu_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain arithmetic on the documented opcode meanings.
    function automatic exp_t model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.ill = 1'b0;
        case (s)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0100: e.res = a ^ b;
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: e.res = a << b[4:0];
            4'b1001: e.res = a >> b[4:0];
            4'b1010: e.res = $unsigned($signed(a) >>> b[4:0]);
            4'b1100: e.res = a * b;
            default: begin e.res = 32'd0; e.ill = 1'b1; end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op; hold it until accepted (bounded), pushing its expectation on acceptance.
    task automatic send(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b, input bit rnd_ready);
        int waited = 0;
        bit taken  = 1'b0;
        alu_sel  = s;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        while (!taken && waited < 200) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(s, a, b));
                taken = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            waited++;
        end
        in_valid = 1'b0;
        if (!taken) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    // Monitor: compare on each transfer, check stability while the consumer stalls.
    logic        hold_prev = 1'b0;
    logic [31:0] prev_res;
    logic        prev_zero;
    logic        prev_ill;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_result", result, prev_res);
                chk("stall_flags", {30'd0, zero, illegal}, {30'd0, prev_zero, prev_ill});
            end
            if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%08h expected no output", result);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("zero", 32'(zero), 32'(e.zero));
                    chk("illegal", 32'(illegal), 32'(e.ill));
                    pop_cyc_q.push_back(cyc);
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_res  = result;
            prev_zero = zero;
            prev_ill  = illegal;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int n0;
        logic [31:0] ra;
        logic [31:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_sel   = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;

        // Reset values
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed single-cycle ops; first one also checks one-cycle latency.
        out_ready = 1'b1;
        send(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(negedge clk);
        chk("add_latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        send(4'b0110, 32'd5, 32'd7, 1'b0);
        send(4'b1010, 32'h8000_0000, 32'h0000_0024, 1'b0);
        send(4'b1001, 32'h8000_0000, 32'h0000_0024, 1'b0);
        send(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        send(4'b1111, 32'h0000_1234, 32'h0000_0000, 1'b0);
        send(4'b0001, 32'h0000_00F0, 32'h0000_000F, 1'b0);

        // MUL latency, second op refused while busy, then 3-cycle stall.
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        send(4'b1100, 32'h0001_0003, 32'h0000_0005, 1'b0);
        in_valid = 1'b1;
        alu_sel  = 4'b0010;
        op_a     = 32'd1;
        op_b     = 32'd2;
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            if (out_valid) break;
            chk("mul_in_ready_low", 32'(in_ready), 32'd0);
            cnt++;
            @(posedge clk);
            #1;
        end
        chk("mul_latency", 32'(cnt), 32'd32);
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("hold_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'b0010, 32'd1, 32'd2, 1'b0);

        // Back-to-back ADDs drain on consecutive cycles.
        repeat (3) begin @(posedge clk); #1; end
        n0 = pop_cyc_q.size();
        for (int i = 0; i < 4; i++) send(4'b0010, $urandom, $urandom, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        chk("b2b_count", 32'(pop_cyc_q.size() - n0), 32'd4);
        if (pop_cyc_q.size() >= n0 + 4) begin
            chk("b2b_consecutive", 32'(pop_cyc_q[n0+3] - pop_cyc_q[n0]), 32'd3);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL b2b_consecutive: got %0d results expected 4", pop_cyc_q.size() - n0);
        end

        // Reset in the middle of a MUL discards it.
        send(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("mulrst_no_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mulrst_out_valid", 32'(out_valid), 32'd0);
        chk("mulrst_in_ready", 32'(in_ready), 32'd1);
        chk("mulrst_result", result, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Randomized ops with random consumer back-pressure.
        for (int i = 0; i < 250; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            send(4'($urandom_range(0, 15)), ra, rb, 1'b1);
        end

        // Drain everything outstanding.
        out_ready = 1'b1;
        cnt = 0;
        while ((exp_q.size() != 0 || out_valid) && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
